// File: rtl/ppg_phase_sequencer_pkg.sv
// ppg_pkg: shared types and constants for the PPG phase sequencer.
// Contents: FSM state enum (the dark states exist only when PPG_AMBIENT_SUB_EN is
// defined), per-channel analog config struct, field widths and a constant log2 helper.
package ppg_pkg;
    localparam int DC_W    = 7;
    localparam int PGA_W   = 4;
    localparam int DRIVE_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        RED_SETTLE,
        RED_ACQ,
        IR_SETTLE,
        IR_ACQ,
`ifdef PPG_AMBIENT_SUB_EN
        DARK_SETTLE,
        DARK_ACQ,
`endif
        PUBLISH
    } ppg_state_t;

    typedef struct packed {
        logic [DC_W-1:0]  dc;
        logic [PGA_W-1:0] pga;
    } ch_cfg_t;

    function automatic int log2_cyc(input int n);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/ppg_phase_sequencer_if.sv
// ppg_phase_sequencer_if: result-pair handshake between the sequencer and its consumer.
// Signals: red_value/ir_value (averaged pair), out_valid, out_ready, overrun (sticky).
// master = sequencer (producer), slave = downstream SpO2/heart-rate logic.
interface ppg_phase_sequencer_if #(parameter int ADC_W = 8);
    logic [ADC_W-1:0] red_value;
    logic [ADC_W-1:0] ir_value;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;

    modport master (output red_value, ir_value, out_valid, overrun, input out_ready);
    modport slave  (input red_value, ir_value, out_valid, overrun, output out_ready);
endinterface

// File: rtl/ppg_phase_sequencer_box_avg.sv
// ppg_box_avg: box averager over SAMPLE_CYC consecutive ADC samples.
// Ports: CLK, rst_n (async active-low), en (accumulate; low clears), adc (sample in),
// avg (truncated mean, valid with done), done (pulse on the cycle of the last sample).
module ppg_box_avg
    import ppg_pkg::*;
#(
    parameter int ADC_W      = 8,
    parameter int SAMPLE_CYC = 8
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             en,
    input  logic [ADC_W-1:0] adc,
    output logic [ADC_W-1:0] avg,
    output logic             done
);
    localparam int L  = log2_cyc(SAMPLE_CYC);
    localparam int SW = ADC_W + L;

    logic [SW-1:0] acc;
    logic [SW-1:0] sum;
    logic [L-1:0]  cnt;

    // The final sample is folded in combinationally so avg is ready with done.
    assign sum  = acc + SW'(adc);
    assign done = en && (cnt == L'(SAMPLE_CYC - 1));
    assign avg  = ADC_W'(sum >> L);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (!en || done) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            acc <= sum;
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ppg_phase_sequencer.sv
// ppg_phase_sequencer: time-multiplexes RED/IR LEDs, applies per-channel DC/PGA,
// waits SETTLE_CYC cycles, box-averages SAMPLE_CYC ADC samples per phase and
// publishes a RED/IR pair per frame over a valid/ready handshake.
// Ports: CLK, rst_n (async active-low), enable, cfg_load + cfg_* (shadow config),
// adc, LED_RED/LED_IR/LED_DRIVE, DC_Comp/PGA_Gain (analog front end),
// res (master: red_value, ir_value, out_valid, out_ready, overrun).
// Build option: PPG_AMBIENT_SUB_EN adds a dark phase and subtracts its average.
module ppg_phase_sequencer
    import ppg_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int SAMPLE_CYC = 8,
    parameter int ADC_W      = 8
) (
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               cfg_load,
    input  logic [DC_W-1:0]    cfg_red_dc,
    input  logic [PGA_W-1:0]   cfg_red_pga,
    input  logic [DC_W-1:0]    cfg_ir_dc,
    input  logic [PGA_W-1:0]   cfg_ir_pga,
    input  logic [DRIVE_W-1:0] cfg_led_drive,
    input  logic [ADC_W-1:0]   adc,
    output logic               LED_RED,
    output logic               LED_IR,
    output logic [DRIVE_W-1:0] LED_DRIVE,
    output logic [DC_W-1:0]    DC_Comp,
    output logic [PGA_W-1:0]   PGA_Gain,
    ppg_phase_sequencer_if.master res
);
    ppg_state_t         state, state_n;
    ch_cfg_t            shd_red, shd_ir, wrk_red, wrk_ir, red_src;
    logic [DRIVE_W-1:0] shd_drv, wrk_drv, drv_src;
    logic [3:0]         scnt;
    logic               settle, acq, settle_done, frame_start, done, publish;
    logic               red_n, ir_n, dark_n;
    logic [ADC_W-1:0]   avg, red_avg, ir_avg;
`ifdef PPG_AMBIENT_SUB_EN
    logic [ADC_W-1:0]   dark_avg;

    assign settle = state inside {RED_SETTLE, IR_SETTLE, DARK_SETTLE};
    assign acq    = state inside {RED_ACQ, IR_ACQ, DARK_ACQ};
    assign dark_n = state_n inside {DARK_SETTLE, DARK_ACQ};
`else
    assign settle = state inside {RED_SETTLE, IR_SETTLE};
    assign acq    = state inside {RED_ACQ, IR_ACQ};
    assign dark_n = 1'b0;
`endif
    assign red_n       = state_n inside {RED_SETTLE, RED_ACQ};
    assign ir_n        = state_n inside {IR_SETTLE, IR_ACQ};
    assign settle_done = settle && (scnt == 4'(SETTLE_CYC - 1));
    assign publish     = state == PUBLISH;
    // Working config is loaded on the frame-start edge, so the RED outputs
    // registered on that same edge must come straight from the shadow.
    assign frame_start = (state_n == RED_SETTLE) && (state != RED_SETTLE);
    assign red_src     = frame_start ? shd_red : wrk_red;
    assign drv_src     = frame_start ? shd_drv : wrk_drv;

    ppg_box_avg #(.ADC_W(ADC_W), .SAMPLE_CYC(SAMPLE_CYC)) u_avg (
        .CLK  (CLK),
        .rst_n(rst_n),
        .en   (acq),
        .adc  (adc),
        .avg  (avg),
        .done (done)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:        state_n = enable ? RED_SETTLE : IDLE;
            RED_SETTLE:  if (settle_done) state_n = RED_ACQ;
            RED_ACQ:     if (done) state_n = IR_SETTLE;
            IR_SETTLE:   if (settle_done) state_n = IR_ACQ;
`ifdef PPG_AMBIENT_SUB_EN
            IR_ACQ:      if (done) state_n = DARK_SETTLE;
            DARK_SETTLE: if (settle_done) state_n = DARK_ACQ;
            DARK_ACQ:    if (done) state_n = PUBLISH;
`else
            IR_ACQ:      if (done) state_n = PUBLISH;
`endif
            default:     state_n = enable ? RED_SETTLE : IDLE;
        endcase
        if (!enable) state_n = IDLE;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            scnt          <= '0;
            shd_red       <= '0;
            shd_ir        <= '0;
            shd_drv       <= '0;
            wrk_red       <= '0;
            wrk_ir        <= '0;
            wrk_drv       <= '0;
            red_avg       <= '0;
            ir_avg        <= '0;
`ifdef PPG_AMBIENT_SUB_EN
            dark_avg      <= '0;
`endif
            LED_RED       <= 1'b0;
            LED_IR        <= 1'b0;
            LED_DRIVE     <= '0;
            DC_Comp       <= '0;
            PGA_Gain      <= '0;
            res.red_value <= '0;
            res.ir_value  <= '0;
            res.out_valid <= 1'b0;
            res.overrun   <= 1'b0;
        end else begin
            state <= state_n;
            scnt  <= (settle && !settle_done) ? scnt + 4'd1 : 4'd0;
            if (cfg_load) begin
                shd_red <= {cfg_red_dc, cfg_red_pga};
                shd_ir  <= {cfg_ir_dc, cfg_ir_pga};
                shd_drv <= cfg_led_drive;
            end
            if (frame_start) begin
                wrk_red <= shd_red;
                wrk_ir  <= shd_ir;
                wrk_drv <= shd_drv;
            end
            LED_RED   <= red_n;
            LED_IR    <= ir_n;
            LED_DRIVE <= (red_n || ir_n) ? drv_src : '0;
            DC_Comp   <= red_n ? red_src.dc : ir_n ? wrk_ir.dc : '0;
            PGA_Gain  <= red_n ? red_src.pga : (ir_n || dark_n) ? wrk_ir.pga : '0;
            if (done && state == RED_ACQ) red_avg <= avg;
            if (done && state == IR_ACQ) ir_avg <= avg;
`ifdef PPG_AMBIENT_SUB_EN
            if (done && state == DARK_ACQ) dark_avg <= avg;
            if (publish) begin
                res.red_value <= (red_avg > dark_avg) ? red_avg - dark_avg : '0;
                res.ir_value  <= (ir_avg > dark_avg) ? ir_avg - dark_avg : '0;
            end
`else
            if (publish) begin
                res.red_value <= red_avg;
                res.ir_value  <= ir_avg;
            end
`endif
            // A publish coinciding with an accept keeps valid high for the new pair.
            res.out_valid <= publish || (res.out_valid && !res.out_ready);
            res.overrun   <= res.overrun || (publish && res.out_valid && !res.out_ready);
        end
    end
endmodule

// File: tb/tb_ppg_phase_sequencer.sv
// tb_ppg_phase_sequencer: directed sequence with randomized ADC/ready traffic,
// checked every cycle against a frame-timing model derived from phase arithmetic.
module tb_ppg_phase_sequencer;
    import ppg_pkg::*;

    localparam int S = 4;
    localparam int N = 8;
    localparam int W = 8;
`ifdef PPG_AMBIENT_SUB_EN
    localparam int NPH   = 3;
    localparam int EXP_R = 30;
    localparam int EXP_I = 0;
`else
    localparam int NPH   = 2;
    localparam int EXP_R = 100;
    localparam int EXP_I = 60;
`endif
    localparam int P = NPH * (S + N) + 1;

    logic         CLK = 1'b0;
    logic         rst_n = 1'b1;
    logic         enable = 1'b0;
    logic         cfg_load = 1'b0;
    logic [6:0]   cfg_red_dc = '0;
    logic [6:0]   cfg_ir_dc = '0;
    logic [3:0]   cfg_red_pga = '0;
    logic [3:0]   cfg_ir_pga = '0;
    logic [3:0]   cfg_led_drive = '0;
    logic [W-1:0] adc = '0;
    logic         LED_RED, LED_IR;
    logic [3:0]   LED_DRIVE, PGA_Gain;
    logic [6:0]   DC_Comp;

    ppg_phase_sequencer_if #(.ADC_W(W)) bus();

    ppg_phase_sequencer #(.SETTLE_CYC(S), .SAMPLE_CYC(N), .ADC_W(W)) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .enable       (enable),
        .cfg_load     (cfg_load),
        .cfg_red_dc   (cfg_red_dc),
        .cfg_red_pga  (cfg_red_pga),
        .cfg_ir_dc    (cfg_ir_dc),
        .cfg_ir_pga   (cfg_ir_pga),
        .cfg_led_drive(cfg_led_drive),
        .adc          (adc),
        .LED_RED      (LED_RED),
        .LED_IR       (LED_IR),
        .LED_DRIVE    (LED_DRIVE),
        .DC_Comp      (DC_Comp),
        .PGA_Gain     (PGA_Gain),
        .res          (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int run_c = -1;
    int rsum = 0, isum = 0, dsum = 0;
    int er = 0, ei = 0;
    logic ev = 1'b0, eo = 1'b0;
    int shd[5] = '{0, 0, 0, 0, 0};
    int wrk[5] = '{0, 0, 0, 0, 0};
    int pend[5] = '{0, 0, 0, 0, 0};
    bit ld_pend = 1'b0;
    int mode = 0;
    int rdy_mode = 1;

    function automatic int chan(input int c);
        if (c < 0 || (c % P) >= NPH * (S + N)) return 0;
        return (c % P) / (S + N) + 1;
    endfunction

    function automatic bit is_acq(input int c);
        return chan(c) != 0 && ((c % P) % (S + N)) >= S;
    endfunction

    function automatic int phase_avg(input int sum, input int dark);
`ifdef PPG_AMBIENT_SUB_EN
        return (sum / N > dark / N) ? sum / N - dark / N : 0;
`else
        return sum / N + 0 * dark;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_led_red"}, LED_RED, 0);
        chk({pfx, "_led_ir"}, LED_IR, 0);
        chk({pfx, "_drive"}, LED_DRIVE, 0);
        chk({pfx, "_dc"}, DC_Comp, 0);
        chk({pfx, "_pga"}, PGA_Gain, 0);
        chk({pfx, "_valid"}, bus.out_valid, 0);
        chk({pfx, "_red"}, bus.red_value, 0);
        chk({pfx, "_ir"}, bus.ir_value, 0);
        chk({pfx, "_overrun"}, bus.overrun, 0);
    endtask

    task automatic step();
        int ch;
        bit prev;
        ch = chan(run_c);
        if (mode == 1 && is_acq(run_c)) adc = W'(ch == 1 ? 100 : ch == 2 ? 60 : 70);
        else if (mode == 2 && is_acq(run_c) && ch == 1) adc = W'((run_c % P) - S);
        else if (mode == 2 && is_acq(run_c) && ch == 3) adc = '0;
        else adc = W'($urandom_range(0, 255));
        bus.out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
        if (is_acq(run_c)) begin
            if (ch == 1) rsum += int'(adc);
            else if (ch == 2) isum += int'(adc);
            else dsum += int'(adc);
        end
        if (run_c >= 0 && (run_c % P) == P - 1) begin
            if (ev && !bus.out_ready) eo = 1'b1;
            ev = 1'b1;
            er = phase_avg(rsum, dsum);
            ei = phase_avg(isum, dsum);
        end else if (ev && bus.out_ready) ev = 1'b0;
        prev = enable;
        @(posedge CLK);
        #1;
        run_c = prev ? run_c + 1 : -1;
        if (run_c >= 0 && (run_c % P) == 0) begin
            wrk = shd;
            rsum = 0;
            isum = 0;
            dsum = 0;
        end
        if (ld_pend) begin
            shd = pend;
            ld_pend = 1'b0;
        end
        ch = chan(run_c);
        chk("led_red", LED_RED, ch == 1);
        chk("led_ir", LED_IR, ch == 2);
        if (ch == 1) begin
            chk("dc_red", DC_Comp, wrk[0]);
            chk("pga_red", PGA_Gain, wrk[1]);
            chk("drive_red", LED_DRIVE, wrk[4]);
        end else if (ch == 2) begin
            chk("dc_ir", DC_Comp, wrk[2]);
            chk("pga_ir", PGA_Gain, wrk[3]);
            chk("drive_ir", LED_DRIVE, wrk[4]);
        end else if (ch == 3) begin
            chk("dc_dark", DC_Comp, 0);
            chk("pga_dark", PGA_Gain, wrk[3]);
        end
        chk("out_valid", bus.out_valid, ev);
        chk("red_value", bus.red_value, er);
        chk("ir_value", bus.ir_value, ei);
        chk("overrun", bus.overrun, eo);
    endtask

    task automatic load_cfg(input int rdc, input int rpga, input int idc, input int ipga, input int drv);
        cfg_red_dc = 7'(rdc);
        cfg_red_pga = 4'(rpga);
        cfg_ir_dc = 7'(idc);
        cfg_ir_pga = 4'(ipga);
        cfg_led_drive = 4'(drv);
        cfg_load = 1'b1;
        pend = '{rdc, rpga, idc, ipga, drv};
        ld_pend = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_zero("reset");
        @(posedge CLK);
        #1 rst_n = 1'b1;

        load_cfg(40, 3, 90, 7, 5);
        mode = 1;
        rdy_mode = 1;
        enable = 1'b1;
        repeat (P) step();
        chk("first_valid_early", bus.out_valid, 0);
        step();
        chk("first_valid", bus.out_valid, 1);
        chk("first_red", bus.red_value, EXP_R);
        chk("first_ir", bus.ir_value, EXP_I);

        mode = 2;
        repeat (P) step();
        chk("ramp_red", bus.red_value, 3);

        mode = 0;
        step();
        rdy_mode = 0;
        repeat (P - 1) step();
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_no_overrun", bus.overrun, 0);
        repeat (P) step();
        chk("overrun_set", bus.overrun, 1);
        rdy_mode = 1;
        step();
        chk("valid_cleared", bus.out_valid, 0);

        load_cfg(20, 1, 110, 9, 12);
        rdy_mode = 2;
        for (int k = 0; k < P && (run_c % P) != S + N; k++) step();
        chk("old_ir_dc", DC_Comp, 90);
        chk("old_ir_pga", PGA_Gain, 7);
        for (int k = 0; k < P && (run_c % P) != 0; k++) step();
        chk("new_red_dc", DC_Comp, 20);
        chk("new_red_pga", PGA_Gain, 1);
        repeat (P) step();

        for (int k = 0; k < P && (run_c % P) != S + 3; k++) step();
        enable = 1'b0;
        step();
        chk("abort_idle", run_c, -1);
        repeat (5) step();
        enable = 1'b1;
        repeat (P + 2) step();

        for (int k = 0; k < P && (run_c % P) != S + 2; k++) step();
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        run_c = -1;
        ev = 1'b0;
        eo = 1'b0;
        er = 0;
        ei = 0;
        shd = '{0, 0, 0, 0, 0};
        wrk = '{0, 0, 0, 0, 0};
        enable = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (4) step();
        load_cfg(int'($urandom_range(0, 127)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 127)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        enable = 1'b1;
        repeat (2 * P + 3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ppg_phase_sequencer.md
Name: ppg_phase_sequencer

Overview:
Run-time scheduler for the optical front end once calibration has produced per-channel settings. It time-multiplexes the RED and IR LEDs, plus an optional dark phase. For each phase it applies that channel's DC compensation and PGA gain, waits for analog settling, then box-averages ADC samples. A RED/IR result pair is published per frame over a valid/ready handshake to downstream SpO2/heart-rate logic.

Parameters:
SETTLE_CYC, 4, cycles after a phase switch during which ADC is ignored (1..15)
SAMPLE_CYC, 8, ADC samples averaged per phase; power of two, 2..64
ADC_W, 8, ADC data width

Ports:
CLK  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run frames while high
cfg_load  in  1  one-cycle pulse: capture cfg_* into shadow registers
cfg_red_dc  in  7  RED DC compensation code
cfg_red_pga  in  4  RED PGA gain
cfg_ir_dc  in  7  IR DC compensation code
cfg_ir_pga  in  4  IR PGA gain
cfg_led_drive  in  4  LED drive current code
adc  in  ADC_W  ADC sample, valid every cycle
LED_RED  out  1  RED LED enable
LED_IR  out  1  IR LED enable
LED_DRIVE  out  4  LED drive code
DC_Comp  out  7  DC compensation to analog front end
PGA_Gain  out  4  PGA gain to analog front end
red_value  out  ADC_W  averaged RED sample
ir_value  out  ADC_W  averaged IR sample
out_valid  out  1  result pair valid
out_ready  in  1  consumer accepts pair
overrun  out  1  sticky: pair overwritten before acceptance

Behaviour:
- Reset (asynchronous, active-low, rst_n; clock CLK): state IDLE. All outputs 0, shadow registers 0, accumulator and counters 0.
- Shadow config: on cfg_load, all cfg_* are captured on the next edge. Shadow values are applied only at frame start (entry to RED_SETTLE), so a frame never mixes settings.
- FSM states: IDLE, RED_SETTLE, RED_ACQ, IR_SETTLE, IR_ACQ, [DARK_SETTLE, DARK_ACQ], PUBLISH.
- IDLE: LEDs off. If enable is high at an edge, go to RED_SETTLE and load the working config from shadow.
- X_SETTLE:
  - The channel's LED is on and the other LED is off.
  - DC_Comp and PGA_Gain carry that channel's working values from the first cycle of the state. LED_DRIVE carries the working drive code.
  - Stay SETTLE_CYC cycles, then go to X_ACQ.
- X_ACQ:
  - Accumulate adc for SAMPLE_CYC cycles into an accumulator of width ADC_W+log2(SAMPLE_CYC). The accumulator clears on entry.
  - Average = sum >> log2(SAMPLE_CYC), truncating, with no rounding.
- DARK phase (feature only): both LEDs off, DC_Comp=0, PGA_Gain=IR gain.
- PUBLISH (1 cycle):
  - LEDs off.
  - red_value/ir_value are registered and out_valid is set on exit.
  - If out_valid was already high and out_ready is low in this cycle, set overrun (sticky until reset) and overwrite the data.
- After PUBLISH: go to RED_SETTLE if enable is high, else IDLE.
- Handshake: out_valid stays high until the cycle in which out_valid&&out_ready; it clears on the following edge. If a publish and an accept coincide, the new pair wins and out_valid stays high.
- enable low in any non-IDLE state aborts at the next edge: IDLE, LEDs off, no publish, accumulator cleared. out_valid and existing data are untouched.
- Latency from enable seen to first out_valid is 2*(SETTLE_CYC+SAMPLE_CYC)+1 edges, which is 25 with defaults. The frame period is the same.
- LED_RED and LED_IR are never simultaneously 1.

Optional Feature:
PPG_AMBIENT_SUB_EN
- Defined:
  - The DARK_SETTLE/DARK_ACQ phases are inserted between IR_ACQ and PUBLISH.
  - red_value = max(red_avg - dark_avg, 0) and ir_value = max(ir_avg - dark_avg, 0), saturating at 0.
  - Frame period is 3*(SETTLE_CYC+SAMPLE_CYC)+1, which is 37 with defaults.
- Undefined: the dark states are absent and raw averages are published.

Decomposition:
- Package ppg_pkg holds:
  - the state enum typedef;
  - the channel config struct {dc[6:0], pga[3:0]};
  - the localparam helper for log2(SAMPLE_CYC);
  - the shared constants DC_W=7, PGA_W=4, DRIVE_W=4.
- One sub-module, ppg_box_avg: a clear/accumulate/average unit parameterised by ADC_W and SAMPLE_CYC, with a done pulse when the sample count is reached. The FSM stays in the top module.

Test Plan:
- Reset mid-frame (assert rst_n low during RED_ACQ) -> all outputs 0 immediately, IDLE, with no out_valid afterwards until enable.
- cfg red 40/3, ir 90/7, enable=1, adc=100 during RED, 60 during IR, out_ready=1 -> out_valid at edge 25, red_value=100, ir_value=60. DC_Comp/PGA_Gain equal 40/3 in RED phases and 90/7 in IR phases.
- adc ramps 0..7 during RED_ACQ -> red_value=3 (sum 28 >> 3).
- out_ready=0 for two frames -> second publish sets overrun=1 and holds the latest pair. Raising out_ready clears out_valid on the next edge.
- cfg_load with new values mid-frame -> the current frame keeps the old DC/PGA, and the next RED_SETTLE shows the new values.
- PPG_AMBIENT_SUB_EN: RED 100, IR 60, dark 70 -> red_value=30, ir_value=0, out_valid at edge 37.
